systolic_modmac_array: RTL and testbench



---
 rtl/systolic_modmac_array.sv | 212 +++++++++++++++++++++
 tb/tb_systolic_modmac_array.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_modmac_array.sv
// systolic_modmac_array
//   Output-stationary ARRAY_ROWS x ARRAY_COLUMNS systolic multiplier computing
//   C = A(ROWS x K) * B(K x COLS) with runtime K (1..K_MAX), optional
//   mod-MODULUS accumulation, a start/busy/done handshake and a row-serial
//   drain port.
// Ports:
//   clk, srstn        clock (rising edge), asynchronous active-low reset
//   alu_start         start request, honoured only in IDLE
//   mod_en, K         mode and inner dimension, latched at start
//   A_vec, B_vec      flattened operand matrices, latched at start
//   busy, done, k_err handshake / status
//   mul_outcome       flattened C, held until the next capture
//   out_valid, out_row, out_array   one row of C per DRAIN cycle
module systolic_modmac_array #(
    parameter int ARRAY_ROWS    = 4,
    parameter int ARRAY_COLUMNS = 4,
    parameter int DATA_WIDTH    = 32,
    parameter int K_MAX         = 16,
    parameter int MODULUS       = 3329,
    parameter int KW            = $clog2(K_MAX + 1),
    parameter int RW            = (ARRAY_ROWS > 1) ? $clog2(ARRAY_ROWS) : 1
) (
    input  logic                                        clk,
    input  logic                                        srstn,
    input  logic                                        alu_start,
    input  logic                                        mod_en,
    input  logic [KW-1:0]                               K,
    input  logic [ARRAY_ROWS*K_MAX*DATA_WIDTH-1:0]      A_vec,
    input  logic [K_MAX*ARRAY_COLUMNS*DATA_WIDTH-1:0]   B_vec,
    output logic                                        busy,
    output logic                                        done,
    output logic                                        k_err,
    output logic [ARRAY_ROWS*ARRAY_COLUMNS*DATA_WIDTH-1:0] mul_outcome,
    output logic                                        out_valid,
    output logic [RW-1:0]                               out_row,
    output logic [ARRAY_COLUMNS*DATA_WIDTH-1:0]         out_array
);
    localparam int DW    = DATA_WIDTH;
    localparam int ACC_W = 2*DW + $clog2(K_MAX);
    localparam int CW    = $clog2(K_MAX + ARRAY_ROWS + ARRAY_COLUMNS + 1);
    localparam logic [DW-1:0] Q_W = DW'(MODULUS);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_COMPUTE, S_DRAIN, S_DONE} state_t;

    state_t r_state, w_state_next;

    logic [ARRAY_ROWS*K_MAX*DW-1:0]    r_a_lat;
    logic [K_MAX*ARRAY_COLUMNS*DW-1:0] r_b_lat;
    logic [KW-1:0]                     r_k;
    logic                              r_mod;
    logic                              r_err;
    logic [CW-1:0]                     r_cnt;
    logic [ARRAY_ROWS*ARRAY_COLUMNS*DW-1:0] r_outcome;

    logic                 w_k_bad;
    logic [CW-1:0]        w_last_t;
    logic [ARRAY_ROWS*ARRAY_COLUMNS*DW-1:0] w_acc_flat;
    logic [DW-1:0]        w_a_edge [ARRAY_ROWS];
    logic [DW-1:0]        w_b_edge [ARRAY_COLUMNS];
    logic [DW-1:0]        w_a_link [ARRAY_ROWS][ARRAY_COLUMNS];
    logic [DW-1:0]        w_b_link [ARRAY_ROWS][ARRAY_COLUMNS];

    assign w_k_bad  = (r_k == '0) || (int'(r_k) > K_MAX);
    // Last compute cycle index: T-1 = K + ROWS + COLS - 3
    assign w_last_t = CW'(r_k) + CW'(ARRAY_ROWS + ARRAY_COLUMNS - 3);

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (alu_start) w_state_next = S_LOAD;
            S_LOAD:    w_state_next = w_k_bad ? S_DONE : S_COMPUTE;
            S_COMPUTE: if (r_cnt == w_last_t) w_state_next = S_DRAIN;
            S_DRAIN:   if (r_cnt == CW'(ARRAY_ROWS - 1)) w_state_next = S_DONE;
            S_DONE:    w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    // ---------------- control / capture ----------------
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            r_a_lat   <= '0;
            r_b_lat   <= '0;
            r_k       <= '0;
            r_mod     <= 1'b0;
            r_err     <= 1'b0;
            r_cnt     <= '0;
            r_outcome <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (alu_start) begin
                    r_a_lat <= A_vec;
                    r_b_lat <= B_vec;
                    r_k     <= K;
                    r_mod   <= mod_en;
                end
                S_LOAD: begin
                    r_cnt <= '0;
                    r_err <= w_k_bad;
                    if (w_k_bad) r_outcome <= '0;
                end
                S_COMPUTE: begin
                    if (r_cnt == w_last_t) begin
                        // Same edge as the final accumulation: take the next values.
                        r_outcome <= w_acc_flat;
                        r_cnt     <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (r_cnt == CW'(ARRAY_ROWS - 1)) r_cnt <= '0;
                    else                               r_cnt <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // ---------------- edge injection (skewed by row / column) ----------------
    genvar gi, gj;
    generate
        for (gi = 0; gi < ARRAY_ROWS; gi++) begin : g_a_inj
            int w_ka;
            always_comb begin
                w_a_edge[gi] = '0;
                w_ka = int'(r_cnt) - gi;
                if (w_ka >= 0 && w_ka < int'(r_k) && w_ka < K_MAX)
                    w_a_edge[gi] = r_a_lat[(gi*K_MAX + w_ka)*DW +: DW];
            end
        end
        for (gj = 0; gj < ARRAY_COLUMNS; gj++) begin : g_b_inj
            int w_kb;
            always_comb begin
                w_b_edge[gj] = '0;
                w_kb = int'(r_cnt) - gj;
                if (w_kb >= 0 && w_kb < int'(r_k) && w_kb < K_MAX)
                    w_b_edge[gj] = r_b_lat[(w_kb*ARRAY_COLUMNS + gj)*DW +: DW];
            end
        end

        // ---------------- processing elements ----------------
        for (gi = 0; gi < ARRAY_ROWS; gi++) begin : g_row
            for (gj = 0; gj < ARRAY_COLUMNS; gj++) begin : g_col
                logic [DW-1:0]    w_a, w_b, w_am, w_bm, w_p;
                logic [2*DW-1:0]  w_prod, w_prod_mod, w_prod_red;
                logic [ACC_W-1:0] w_sum, w_acc_next;
                logic [DW-1:0]    r_a_fwd, r_b_fwd;
                logic [ACC_W-1:0] r_acc;

                if (gj == 0) begin : g_a_src
                    assign w_a = w_a_edge[gi];
                end else begin : g_a_src
                    assign w_a = w_a_link[gi][gj-1];
                end
                if (gi == 0) begin : g_b_src
                    assign w_b = w_b_edge[gj];
                end else begin : g_b_src
                    assign w_b = w_b_link[gi-1][gj];
                end

                // Operands are reduced first so any input value is legal and
                // the product of residues fits in 2*DW bits.
                assign w_am       = w_a % Q_W;
                assign w_bm       = w_b % Q_W;
                assign w_prod     = {{DW{1'b0}}, w_a} * {{DW{1'b0}}, w_b};
                assign w_prod_mod = {{DW{1'b0}}, w_am} * {{DW{1'b0}}, w_bm};
                assign w_prod_red = w_prod_mod % {{DW{1'b0}}, Q_W};
                assign w_p        = w_prod_red[DW-1:0];
                assign w_sum      = r_acc + (r_mod ? ACC_W'(w_p) : ACC_W'(w_prod));
                // acc < Q and p < Q, so one conditional subtract keeps acc < Q.
                assign w_acc_next = (r_mod && (w_sum >= ACC_W'(Q_W))) ? (w_sum - ACC_W'(Q_W)) : w_sum;

                always_ff @(posedge clk or negedge srstn) begin
                    if (!srstn) begin
                        r_a_fwd <= '0;
                        r_b_fwd <= '0;
                        r_acc   <= '0;
                    end else if (r_state == S_LOAD) begin
                        r_a_fwd <= '0;
                        r_b_fwd <= '0;
                        r_acc   <= '0;
                    end else if (r_state == S_COMPUTE) begin
                        r_a_fwd <= w_a;
                        r_b_fwd <= w_b;
                        r_acc   <= w_acc_next;
                    end
                end

                assign w_a_link[gi][gj] = r_a_fwd;
                assign w_b_link[gi][gj] = r_b_fwd;
                assign w_acc_flat[(gi*ARRAY_COLUMNS + gj)*DW +: DW] = w_acc_next[DW-1:0];
            end
        end
    endgenerate

    // ---------------- outputs ----------------
    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_DONE);
    assign k_err       = (r_state == S_DONE) && r_err;
    assign out_valid   = (r_state == S_DRAIN);
    assign out_row     = out_valid ? r_cnt[RW-1:0] : '0;
    assign out_array   = out_valid ? r_outcome[int'(r_cnt)*ARRAY_COLUMNS*DW +: ARRAY_COLUMNS*DW] : '0;
    assign mul_outcome = r_outcome;

endmodule

// File: tb/tb_systolic_modmac_array.sv
// Self-checking bench for systolic_modmac_array (4x4, 32-bit, K_MAX=16, Q=3329).
module tb_systolic_modmac_array;
    localparam int R  = 4;
    localparam int C  = 4;
    localparam int DW = 32;
    localparam int KM = 16;
    localparam int Q  = 3329;
    localparam int KW = 5;
    localparam int RW = 2;

    logic clk = 1'b0;
    logic srstn = 1'b0;
    logic alu_start = 1'b0;
    logic mod_en = 1'b0;
    logic [KW-1:0] K = '0;
    logic [R*KM*DW-1:0] A_vec = '0;
    logic [KM*C*DW-1:0] B_vec = '0;
    logic busy, done, k_err, out_valid;
    logic [R*C*DW-1:0] mul_outcome;
    logic [RW-1:0] out_row;
    logic [C*DW-1:0] out_array;

    systolic_modmac_array #(
        .ARRAY_ROWS(R), .ARRAY_COLUMNS(C), .DATA_WIDTH(DW), .K_MAX(KM), .MODULUS(Q)
    ) dut (
        .clk(clk), .srstn(srstn), .alu_start(alu_start), .mod_en(mod_en), .K(K),
        .A_vec(A_vec), .B_vec(B_vec), .busy(busy), .done(done), .k_err(k_err),
        .mul_outcome(mul_outcome), .out_valid(out_valid), .out_row(out_row),
        .out_array(out_array)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Stimulus / model state
    logic [DW-1:0] A_m [R][KM];
    logic [DW-1:0] B_m [KM][C];
    int            k_m;
    bit            mod_m;
    logic [R*C*DW-1:0] exp_flat;

    // Observations of the last run
    int obs_busy, obs_done_cnt, obs_done_at, obs_stray;
    bit obs_kerr, obs_timeout;
    int obs_rows [$];
    logic [C*DW-1:0] obs_data [$];

    // Reference: C[i][j] = sum_k A[i][k]*B[k][j], either mod 2^DW or mod Q.
    task automatic model_compute();
        longint unsigned acc, a64, b64;
        exp_flat = '0;
        if (k_m >= 1 && k_m <= KM) begin
            for (int i = 0; i < R; i++)
                for (int j = 0; j < C; j++) begin
                    acc = 0;
                    for (int k = 0; k < k_m; k++) begin
                        a64 = A_m[i][k];
                        b64 = B_m[k][j];
                        if (mod_m) acc = (acc + ((a64 % Q) * (b64 % Q)) % Q) % Q;
                        else       acc = acc + a64 * b64;
                    end
                    exp_flat[(i*C+j)*DW +: DW] = acc[DW-1:0];
                end
        end
    endtask

    task automatic apply_inputs();
        for (int i = 0; i < R; i++)
            for (int k = 0; k < KM; k++) A_vec[(i*KM+k)*DW +: DW] = A_m[i][k];
        for (int k = 0; k < KM; k++)
            for (int j = 0; j < C; j++) B_vec[(k*C+j)*DW +: DW] = B_m[k][j];
        K = KW'(k_m);
        mod_en = mod_m;
    endtask

    // Starts one run from IDLE and records what the DUT does until busy drops.
    task automatic do_run();
        bit ended;
        apply_inputs();
        model_compute();
        alu_start = 1'b1;
        @(posedge clk); #1;
        alu_start = 1'b0;
        obs_busy = 0; obs_done_cnt = 0; obs_done_at = 0; obs_stray = 0;
        obs_kerr = 1'b0; obs_timeout = 1'b0; ended = 1'b0;
        obs_rows.delete(); obs_data.delete();
        for (int cyc = 1; cyc <= 300; cyc++) begin
            if (!busy) begin ended = 1'b1; break; end
            obs_busy++;
            if (done) begin obs_done_cnt++; obs_done_at = cyc; obs_kerr = k_err; end
            else if (k_err) obs_stray++;
            if (out_valid) begin
                obs_rows.push_back(int'(out_row));
                obs_data.push_back(out_array);
            end else if (out_row != '0 || out_array != '0) obs_stray++;
            @(posedge clk); #1;
        end
        if (!ended) obs_timeout = 1'b1;
    endtask

    task automatic set_scenario1();
        for (int i = 0; i < R; i++)
            for (int k = 0; k < KM; k++) A_m[i][k] = (k == i) ? 32'd1 : 32'd0;
        for (int k = 0; k < KM; k++)
            for (int j = 0; j < C; j++) B_m[k][j] = 32'(4*k + j + 1);
        k_m = 4; mod_m = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        srstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({busy, done, k_err, out_valid} !== 4'b0 || out_row !== '0 || out_array !== '0 || mul_outcome !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: busy=%0b done=%0b k_err=%0b out_valid=%0b nonzero_outcome=%0b, required all zero",
                     busy, done, k_err, out_valid, |mul_outcome);
        end
        srstn = 1'b1;
        @(posedge clk); #1;
        $display("reset test: outputs checked");
    endtask

    task automatic test_identity();
        set_scenario1();
        do_run();
        n_vec++;
        if (obs_timeout || obs_busy != 16) begin
            n_bad++; $display("FAIL id_busy_cycles: got %0d (timeout=%0b), required 16", obs_busy, obs_timeout);
        end
        n_vec++;
        if (obs_done_cnt != 1 || obs_done_at != 16) begin
            n_bad++; $display("FAIL id_done_cycle: got count=%0d at=%0d, required 1 at 16", obs_done_cnt, obs_done_at);
        end
        for (int i = 0; i < R; i++)
            for (int j = 0; j < C; j++) begin
                n_vec++;
                if (mul_outcome[(i*C+j)*DW +: DW] !== 32'(4*i + j + 1)) begin
                    n_bad++;
                    $display("FAIL id_c[%0d][%0d]: got %0d, required %0d", i, j, mul_outcome[(i*C+j)*DW +: DW], 4*i+j+1);
                end
            end
        n_vec++;
        if (obs_rows.size() != R || obs_stray != 0) begin
            n_bad++; $display("FAIL id_drain_count: got rows=%0d stray=%0d, required %0d and 0", obs_rows.size(), obs_stray, R);
        end
        for (int r = 0; r < obs_rows.size() && r < R; r++) begin
            n_vec++;
            if (obs_rows[r] != r || obs_data[r] !== exp_flat[r*C*DW +: C*DW]) begin
                n_bad++; $display("FAIL id_drain_row%0d: got row %0d data %h, required row %0d data %h",
                                  r, obs_rows[r], obs_data[r], r, exp_flat[r*C*DW +: C*DW]);
            end
        end
        $display("identity test: busy=%0d done_at=%0d", obs_busy, obs_done_at);
    endtask

    task automatic test_short_k();
        for (int i = 0; i < R; i++)
            for (int k = 0; k < KM; k++) A_m[i][k] = (k < 2) ? 32'd1 : 32'hFFFF_FFFF;
        for (int k = 0; k < KM; k++)
            for (int j = 0; j < C; j++) B_m[k][j] = (k == 0) ? 32'(j) : (k == 1) ? 32'd10 : $urandom;
        k_m = 2; mod_m = 1'b0;
        do_run();
        n_vec++;
        if (obs_done_at != 14 || obs_busy != 14) begin
            n_bad++; $display("FAIL shortk_done: got done_at=%0d busy=%0d, required 14", obs_done_at, obs_busy);
        end
        for (int i = 0; i < R; i++)
            for (int j = 0; j < C; j++) begin
                n_vec++;
                if (mul_outcome[(i*C+j)*DW +: DW] !== 32'(j + 10)) begin
                    n_bad++; $display("FAIL shortk_c[%0d][%0d]: got %0d, required %0d", i, j, mul_outcome[(i*C+j)*DW +: DW], j+10);
                end
            end
        $display("short-K test: done_at=%0d", obs_done_at);
    endtask

    task automatic test_modular();
        for (int i = 0; i < R; i++) for (int k = 0; k < KM; k++) A_m[i][k] = 32'd3328;
        for (int k = 0; k < KM; k++) for (int j = 0; j < C; j++) B_m[k][j] = 32'd3328;
        k_m = 16; mod_m = 1'b1;
        do_run();
        for (int e = 0; e < R*C; e++) begin
            n_vec++;
            if (mul_outcome[e*DW +: DW] !== 32'd16) begin
                n_bad++; $display("FAIL mod_neg1_c%0d: got %0d, required 16", e, mul_outcome[e*DW +: DW]);
            end
        end
        n_vec++;
        if (obs_busy != 2 + 16 + R + C - 2 + R) begin
            n_bad++; $display("FAIL mod_busy: got %0d, required %0d", obs_busy, 2 + 16 + R + C - 2 + R);
        end
        for (int i = 0; i < R; i++) for (int k = 0; k < KM; k++) A_m[i][k] = 32'd5000;
        for (int k = 0; k < KM; k++) for (int j = 0; j < C; j++) B_m[k][j] = 32'd1;
        k_m = 1;
        do_run();
        for (int e = 0; e < R*C; e++) begin
            n_vec++;
            if (mul_outcome[e*DW +: DW] !== 32'd1671) begin
                n_bad++; $display("FAIL mod_5000_c%0d: got %0d, required 1671", e, mul_outcome[e*DW +: DW]);
            end
        end
        $display("modular test: two runs checked");
    endtask

    task automatic test_truncation();
        for (int i = 0; i < R; i++) for (int k = 0; k < KM; k++) A_m[i][k] = 32'hFFFF_FFFF;
        for (int k = 0; k < KM; k++) for (int j = 0; j < C; j++) B_m[k][j] = 32'hFFFF_FFFF;
        k_m = 1; mod_m = 1'b0;
        do_run();
        for (int e = 0; e < R*C; e++) begin
            n_vec++;
            if (mul_outcome[e*DW +: DW] !== 32'h0000_0001) begin
                n_bad++; $display("FAIL trunc_c%0d: got %h, required 00000001", e, mul_outcome[e*DW +: DW]);
            end
        end
        $display("truncation test: checked");
    endtask

    task automatic test_k_error();
        int bad_k [2];
        int n_done, n_idle;
        bad_k[0] = 0; bad_k[1] = KM + 1;
        for (int t = 0; t < 2; t++) begin
            set_scenario1();
            k_m = bad_k[t];
            do_run();
            n_vec++;
            if (obs_busy != 2 || obs_done_at != 2 || !obs_kerr || obs_stray != 0) begin
                n_bad++; $display("FAIL kerr_K%0d: got busy=%0d done_at=%0d k_err=%0b stray=%0d, required 2 2 1 0",
                                  bad_k[t], obs_busy, obs_done_at, obs_kerr, obs_stray);
            end
            n_vec++;
            if (mul_outcome !== '0 || obs_rows.size() != 0) begin
                n_bad++; $display("FAIL kerr_outcome_K%0d: got nonzero=%0b rows=%0d, required 0 and 0",
                                  bad_k[t], |mul_outcome, obs_rows.size());
            end
        end
        // alu_start held high: one run per IDLE visit (16 busy + 1 idle).
        set_scenario1();
        apply_inputs();
        n_done = 0; n_idle = 0;
        alu_start = 1'b1;
        for (int cyc = 1; cyc <= 51; cyc++) begin
            @(posedge clk); #1;
            if (done) n_done++;
            if (!busy) n_idle++;
        end
        alu_start = 1'b0;
        n_vec++;
        if (n_done != 3 || n_idle != 3) begin
            n_bad++; $display("FAIL held_start: got done=%0d idle=%0d, required 3 and 3", n_done, n_idle);
        end
        @(posedge clk); #1;
        $display("k-error test: held start gave %0d runs", n_done);
    endtask

    task automatic test_reset_midrun();
        int n_done;
        set_scenario1();
        apply_inputs();
        alu_start = 1'b1;
        @(posedge clk); #1;
        alu_start = 1'b0;
        repeat (6) @(posedge clk);   // now in COMPUTE with t=5
        #1;
        srstn = 1'b0;
        #1;
        n_vec++;
        if ({busy, done, k_err, out_valid} !== 4'b0 || mul_outcome !== '0 || out_array !== '0) begin
            n_bad++; $display("FAIL midrun_reset: got busy=%0b done=%0b nonzero_outcome=%0b, required all zero",
                              busy, done, |mul_outcome);
        end
        n_done = 0;
        repeat (3) begin @(posedge clk); #1; if (done || busy) n_done++; end
        srstn = 1'b1;
        repeat (2) begin @(posedge clk); #1; if (done || busy) n_done++; end
        n_vec++;
        if (n_done != 0) begin
            n_bad++; $display("FAIL midrun_no_done: got %0d busy/done cycles, required 0", n_done);
        end
        do_run();
        n_vec++;
        if (obs_busy != 16 || obs_done_at != 16 || mul_outcome !== exp_flat) begin
            n_bad++; $display("FAIL midrun_rerun: got busy=%0d done_at=%0d outcome %h, required 16 16 %h",
                              obs_busy, obs_done_at, mul_outcome, exp_flat);
        end
        $display("mid-run reset test: rerun busy=%0d", obs_busy);
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            mod_m = 1'($urandom_range(0, 1));
            k_m = $urandom_range(1, KM);
            for (int i = 0; i < R; i++) for (int k = 0; k < KM; k++) A_m[i][k] = $urandom;
            for (int k = 0; k < KM; k++) for (int j = 0; j < C; j++) B_m[k][j] = $urandom;
            do_run();
            n_vec++;
            if (mul_outcome !== exp_flat) begin
                n_bad++; $display("FAIL rand%0d_outcome (mod=%0b K=%0d): got %h, required %h",
                                  it, mod_m, k_m, mul_outcome, exp_flat);
            end
            n_vec++;
            if (obs_busy != k_m + R + C + R || obs_done_at != obs_busy || obs_rows.size() != R || obs_stray != 0) begin
                n_bad++; $display("FAIL rand%0d_timing: got busy=%0d done_at=%0d rows=%0d stray=%0d, required %0d",
                                  it, obs_busy, obs_done_at, obs_rows.size(), obs_stray, k_m + 2*R + C);
            end
            for (int r = 0; r < obs_rows.size() && r < R; r++) begin
                n_vec++;
                if (obs_rows[r] != r || obs_data[r] !== exp_flat[r*C*DW +: C*DW]) begin
                    n_bad++; $display("FAIL rand%0d_drain%0d: got row %0d data %h, required row %0d data %h",
                                      it, r, obs_rows[r], obs_data[r], r, exp_flat[r*C*DW +: C*DW]);
                end
            end
            $display("random run %0d: mod=%0b K=%0d busy=%0d", it, mod_m, k_m, obs_busy);
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_short_k();
        test_modular();
        test_truncation();
        test_k_error();
        test_reset_midrun();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Global guard so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end
endmodule
